mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequencing controller between the pipelined ARM core's data-memory port and the four memory-mapped regions: data RAM, frame buffer, camera register and peripheral window.
- Decodes each request address against the system memory map and asserts a one-hot region select.
- Holds the access for a per-region wait-state count plus any target-driven busy extension.
- Returns read data with a single-cycle ready pulse, or an error for unmapped or timed-out accesses.

Parameters:
- LIMIT_A, 'h40000: exclusive upper bound of region 0 (RAM).
- LIMIT_B, 'h60000: exclusive upper bound of region 1 (frame buffer).
- LIMIT_C, 'h60004: exclusive upper bound of region 2 (camera register).
- LIMIT_D, 'h80000: exclusive upper bound of region 3 (peripherals); addresses at or above LIMIT_D are unmapped.
- WAIT0, 0: wait states for region 0 (4-bit value).
- WAIT1, 1: wait states for region 1.
- WAIT2, 2: wait states for region 2.
- WAIT3, 3: wait states for region 3.
- TIMEOUT, 15: maximum number of busy-extension cycles before the access is aborted with an error (8-bit value).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  access request from the core; held until ready.
- we  in  1  1 = write, 0 = read.
- address  in  32  byte address of the access.
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ready=1 and err=0.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; 1 = access aborted.
- stall  out  1  combinational: req & ~ready.
- mem_select  out  4  one-hot region select; bit n selects region n.
- mem_we  out  1  write strobe to the selected region.
- mem_addr  out  32  latched address driven to the regions.
- mem_wdata  out  32  latched write data.
- mem_busy  in  4  per-region busy; bit n extends the wait for region n.
- mem_rdata0..mem_rdata3  in  32 each  read data returned by regions 0..3.

Behaviour:
- Reset values: state IDLE; rdata, mem_addr, mem_wdata = 0; ready, err, mem_we = 0; mem_select = 0; both counters = 0.
- Reset asserted mid-access aborts immediately. No ready pulse is produced and mem_we drops, so no write completes.
- Decode uses unsigned compares on the full 32-bit address, with each lower bound inclusive:
  - region 0: address < LIMIT_A
  - region 1: LIMIT_A <= address < LIMIT_B
  - region 2: LIMIT_B <= address < LIMIT_C
  - region 3: LIMIT_C <= address < LIMIT_D
  - unmapped: address >= LIMIT_D
- States: IDLE, WAIT, DONE, ERR.
- IDLE:
  - On req=1, latch address, wdata and we into mem_addr, mem_wdata and the internal write flag.
  - Mapped address: go to WAIT with wcnt = WAITn and tcnt = 0; mem_select is set to one-hot n on the same edge.
  - Unmapped address: go to ERR with mem_select = 0.
  - With req=0, remain in IDLE.
- WAIT:
  - mem_we = latched we for the whole state; mem_select is held.
  - If wcnt > 0: decrement wcnt.
  - Else if mem_busy[n] = 0: capture mem_rdataN into rdata (reads only; writes leave rdata unchanged) and go to DONE.
  - Else if tcnt = TIMEOUT: go to ERR.
  - Else: increment tcnt.
- A target samples a write on the cycle where wcnt = 0 and busy = 0.
- DONE: ready = 1 and err = 0 for exactly one cycle. mem_select and mem_we are cleared on entry. Go to IDLE next.
- ERR: ready = 1 and err = 1 for one cycle. rdata is forced to 0 and mem_select = 0. Go to IDLE next.
- Latency:
  - Request sampled at edge t with no busy: ready is high for the cycle following edge t+1+WAITn.
  - Unmapped request: ready is high for the cycle following edge t.
- A new request is accepted only in IDLE. If req is still high during DONE/ERR, it starts a new access on the edge back in IDLE; the core drops or updates req in the ready cycle.
- Changes on address, we or wdata after the request is accepted are ignored until IDLE.
- mem_busy bits for non-selected regions are ignored.

Test Plan:
- Region 0 read: address='h00010 with mem_rdata0='hCAFE0001 -> mem_select=4'b0001 one cycle after the req edge; ready high 1 cycle later; rdata='hCAFE0001; err=0.
- Region boundaries: reads at 'h3FFFC, 'h40000, 'h5FFFC, 'h60000, 'h60004, 'h7FFFC:
  - mem_select = 0001, 0010, 0010, 0100, 1000, 1000 respectively.
  - Ready latency is 1, 2, 2, 3, 4, 4 cycles after the req edge.
- Unmapped: address='h80000, then 'h90000 -> ERR; ready=1 and err=1 on the next cycle; mem_select stays 0; rdata=0.
- Region 3 write: address='h70000, wdata='h12345678, mem_busy[3] held for 2 extra cycles:
  - mem_we=1 and mem_wdata='h12345678 held for 6 cycles.
  - ready then pulses with err=0.
  - stall=1 throughout the access.
- Timeout: region 2 access with mem_busy[2] stuck at 1 -> err pulse after WAIT2 + TIMEOUT + 1 WAIT cycles; mem_select clears.
- Reset in WAIT: assert reset during a region 1 access -> all outputs 0 asynchronously and no ready pulse. A fresh request after reset is released completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: decodes core requests onto four mapped regions,
// inserts per-region wait states plus busy extension, and returns ready/err.
module mem_access_ctrl #(
  parameter logic [31:0] LIMIT_A = 32'h0004_0000,
  parameter logic [31:0] LIMIT_B = 32'h0006_0000,
  parameter logic [31:0] LIMIT_C = 32'h0006_0004,
  parameter logic [31:0] LIMIT_D = 32'h0008_0000,
  parameter logic [3:0]  WAIT0   = 4'd0,
  parameter logic [3:0]  WAIT1   = 4'd1,
  parameter logic [3:0]  WAIT2   = 4'd2,
  parameter logic [3:0]  WAIT3   = 4'd3,
  parameter logic [7:0]  TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall,
  output logic [3:0]  mem_select,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [3:0]  mem_busy,
  input  logic [31:0] mem_rdata0,
  input  logic [31:0] mem_rdata1,
  input  logic [31:0] mem_rdata2,
  input  logic [31:0] mem_rdata3
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_wcnt, w_wcnt_nxt;
  logic [7:0]  r_tcnt, w_tcnt_nxt;
  logic [1:0]  r_region, w_region;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic        w_mapped;
  logic [3:0]  w_wait_sel;
  logic [31:0] w_rdata_sel;
  logic        w_load, w_capture, w_clear;

  // Unsigned decode of the live request address; lower bounds are inclusive.
  always_comb begin
    w_mapped = 1'b1;
    w_region = 2'd0;
    if      (address < LIMIT_A) w_region = 2'd0;
    else if (address < LIMIT_B) w_region = 2'd1;
    else if (address < LIMIT_C) w_region = 2'd2;
    else if (address < LIMIT_D) w_region = 2'd3;
    else                        w_mapped = 1'b0;
  end

  always_comb begin
    case (w_region)
      2'd0:    w_wait_sel = WAIT0;
      2'd1:    w_wait_sel = WAIT1;
      2'd2:    w_wait_sel = WAIT2;
      default: w_wait_sel = WAIT3;
    endcase
  end

  always_comb begin
    case (r_region)
      2'd0:    w_rdata_sel = mem_rdata0;
      2'd1:    w_rdata_sel = mem_rdata1;
      2'd2:    w_rdata_sel = mem_rdata2;
      default: w_rdata_sel = mem_rdata3;
    endcase
  end

  // NOTE: every signal driven here gets a default first; a path that left one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_tcnt_nxt  = r_tcnt;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_load = 1'b1;
          if (w_mapped) begin
            w_state_nxt = S_WAIT;
            w_wcnt_nxt  = w_wait_sel;
            w_tcnt_nxt  = 8'd0;
          end else begin
            w_state_nxt = S_ERR;
            w_clear     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (r_wcnt != 4'd0) begin
          w_wcnt_nxt = r_wcnt - 4'd1;
        end else if (!mem_busy[r_region]) begin
          w_state_nxt = S_DONE;
          w_capture   = ~r_we;
        end else if (r_tcnt == TIMEOUT) begin
          w_state_nxt = S_ERR;
          w_clear     = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_wcnt   <= '0;
      r_tcnt   <= '0;
      r_region <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_load) begin
        r_addr   <= address;
        r_wdata  <= wdata;
        r_we     <= we;
        r_region <= w_region;
      end
      if (w_capture)    r_rdata <= w_rdata_sel;
      else if (w_clear) r_rdata <= '0;
    end
  end

  // Select and write strobe exist only while the access is held in WAIT.
  assign mem_select = (r_state == S_WAIT) ? (4'b0001 << r_region) : 4'b0000;
  assign mem_we     = (r_state == S_WAIT) & r_we;
  assign ready      = (r_state == S_DONE) | (r_state == S_ERR);
  assign err        = (r_state == S_ERR);
  assign stall      = req & ~ready;
  assign rdata      = r_rdata;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed memory-map cases plus
// randomized accesses scored against a latency/decode model of the memory map.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        ready, err, stall;
  logic [3:0]  mem_select;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_busy;
  logic [31:0] mem_rd [4];

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_rdata;

  localparam int TIMEOUT_C = 15;
  logic [31:0] limit_tbl [4] = '{32'h40000, 32'h60000, 32'h60004, 32'h80000};
  int          wait_tbl  [4] = '{0, 1, 2, 3};

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .stall(stall), .mem_select(mem_select),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_rdata0(mem_rd[0]), .mem_rdata1(mem_rd[1]), .mem_rdata2(mem_rd[2]), .mem_rdata3(mem_rd[3])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Region index from the memory map, -1 when unmapped.
  function automatic int region_of(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (a < limit_tbl[i]) return i;
    return -1;
  endfunction

  // One complete access; the target holds busy for the first wait+ext cycles.
  task automatic do_access(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input int ext, input bit hold_req);
    int         r, wn, lat, lat_exp, we_cnt, sel_bad, stall_bad;
    bit         exp_err;
    logic [3:0] sel_exp;
    r = region_of(a);
    wn = (r >= 0) ? wait_tbl[r] : 0;
    sel_exp = (r >= 0) ? (4'b0001 << r) : 4'b0000;
    if (r < 0) begin
      exp_err = 1'b1; lat_exp = 0;
    end else if (ext > TIMEOUT_C) begin
      exp_err = 1'b1; lat_exp = 1 + wn + TIMEOUT_C;
    end else begin
      exp_err = 1'b0; lat_exp = 1 + wn + ext;
    end
    for (int i = 0; i < 4; i++) mem_rd[i] = $urandom();
    @(negedge clk);
    req = 1'b1; we = w; address = a; wdata = d; mem_busy = 4'($urandom());
    @(posedge clk); #1;
    check($sformatf("mem_addr@%h", a), mem_addr, a);
    check($sformatf("mem_wdata@%h", a), mem_wdata, d);
    lat = 0; we_cnt = 0; sel_bad = 0; stall_bad = 0;
    while (!ready && lat < 64) begin
      if (mem_select !== sel_exp) sel_bad++;
      if (stall !== 1'b1) stall_bad++;
      if (mem_we === 1'b1) we_cnt++;
      @(negedge clk);
      address = $urandom(); wdata = $urandom(); we = 1'($urandom());
      mem_busy = 4'($urandom());
      if (r >= 0) mem_busy[r] = (lat + 1 <= wn + ext);
      @(posedge clk); #1;
      lat++;
    end
    if (exp_err) exp_rdata = '0;
    else if (!w) exp_rdata = mem_rd[r];
    check($sformatf("latency@%h", a), 32'(lat), 32'(lat_exp));
    check($sformatf("ready@%h", a), 32'(ready), 32'd1);
    check($sformatf("err@%h", a), 32'(err), 32'(exp_err));
    check($sformatf("rdata@%h", a), rdata, exp_rdata);
    check($sformatf("sel_end@%h", a), 32'(mem_select), 32'd0);
    check($sformatf("we_end@%h", a), 32'(mem_we), 32'd0);
    check($sformatf("stall_rdy@%h", a), 32'(stall), 32'd0);
    check($sformatf("we_cycles@%h", a), 32'(we_cnt), (w && r >= 0) ? 32'(lat_exp) : 32'd0);
    check($sformatf("sel_hold@%h", a), 32'(sel_bad), 32'd0);
    check($sformatf("stall_hold@%h", a), 32'(stall_bad), 32'd0);
    @(negedge clk);
    req = hold_req; mem_busy = 4'b0000; address = a; we = w; wdata = d;
    @(posedge clk); #1;
    check($sformatf("pulse_end@%h", a), 32'(ready), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bnd [6];
    logic [31:0] a;
    int          pick, ext;
    reset = 1'b1; req = 1'b0; we = 1'b0; address = '0; wdata = '0; mem_busy = '0;
    for (int i = 0; i < 4; i++) mem_rd[i] = '0;
    exp_rdata = '0;
    #12;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sel", 32'(mem_select), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    @(negedge clk); reset = 1'b0;

    do_access(32'h00010, 1'b0, 32'h0, 0, 1'b0);
    bnd = '{32'h3FFFC, 32'h40000, 32'h5FFFC, 32'h60000, 32'h60004, 32'h7FFFC};
    for (int i = 0; i < 6; i++) do_access(bnd[i], 1'b0, 32'h0, 0, 1'b0);
    do_access(32'h80000, 1'b0, 32'h0, 0, 1'b0);
    do_access(32'h90000, 1'b0, 32'h0, 0, 1'b0);
    do_access(32'hFFFF_FFFC, 1'b1, 32'h5555_AAAA, 0, 1'b0);
    do_access(32'h70000, 1'b1, 32'h1234_5678, 2, 1'b0);
    do_access(32'h60000, 1'b0, 32'h0, 100, 1'b0);
    do_access(32'h60000, 1'b0, 32'h0, TIMEOUT_C, 1'b1);
    do_access(32'h00100, 1'b0, 32'h0, 0, 1'b0);

    // Reset during a region 1 write: everything drops at once, no ready.
    @(negedge clk);
    req = 1'b1; we = 1'b1; address = 32'h50000; wdata = 32'hDEAD_BEEF; mem_busy = 4'b0010;
    @(posedge clk); #1;
    check("mid_sel", 32'(mem_select), 32'b0010);
    check("mid_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    exp_rdata = '0;
    check("arst_sel", 32'(mem_select), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_ready", 32'(ready), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_noready", 32'(ready), 32'd0);
    end
    @(negedge clk); reset = 1'b0;
    do_access(32'h48000, 1'b0, 32'h0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      pick = $urandom_range(0, 4);
      case (pick)
        0:       a = $urandom_range(32'h0, 32'h3FFFF);
        1:       a = $urandom_range(32'h40000, 32'h5FFFF);
        2:       a = $urandom_range(32'h60000, 32'h60003);
        3:       a = $urandom_range(32'h60004, 32'h7FFFF);
        default: a = $urandom_range(32'h80000, 32'hFFFF_FFFF);
      endcase
      case ($urandom_range(0, 9))
        0:       ext = TIMEOUT_C + 1;
        1:       ext = TIMEOUT_C;
        default: ext = $urandom_range(0, 4);
      endcase
      do_access(a, 1'($urandom()), $urandom(), ext, 1'($urandom()));
    end

    @(negedge clk); req = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
